// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS core: boot hold, load-use stall,
// jump/branch flush, MDU issue blocking and data-memory freeze. Optional perf counters: HAZ_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int BOOT_CYC = 2,
    parameter int MDU_LAT  = 4,
    parameter int CNT_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_uses_rs_i,
    input  logic              id_uses_rt_i,
    input  logic              id_jump_i,
    input  logic              id_mdu_start_i,
    input  logic              ex_mem_read_i,
    input  logic [REG_AW-1:0] ex_rt_i,
    input  logic              ex_branch_taken_i,
    input  logic              dmem_busy_i,
    output logic              pc_keep_o,
    output logic              ifid_keep_o,
    output logic              ifid_flush_o,
    output logic              idex_bubble_o,
    output logic              freeze_o,
    output logic              mdu_busy_o,
    output logic [1:0]        state_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    localparam int BOOT_W = (BOOT_CYC > 1) ? $clog2(BOOT_CYC) : 1;
    localparam int MDU_W  = $clog2(MDU_LAT);
    localparam logic [BOOT_W-1:0] BOOT_INIT = BOOT_W'(BOOT_CYC - 1);
    localparam logic [MDU_W-1:0]  MDU_INIT  = MDU_W'(MDU_LAT - 1);

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MDU_WAIT = 2'd2
    } state_t;

    state_t            state;
    logic [BOOT_W-1:0] boot_cnt;
    logic [MDU_W-1:0]  mdu_cnt;

    logic rs_hit;
    logic rt_hit;
    logic load_use;
    logic mdu_accept;

    assign rs_hit   = id_uses_rs_i && (id_rs_i == ex_rt_i);
    assign rt_hit   = id_uses_rt_i && (id_rt_i == ex_rt_i);
    assign load_use = ex_mem_read_i && (ex_rt_i != '0) && (rs_hit || rt_hit);

    // An MDU op only issues when nothing of higher priority (freeze, wrong path, load-use) claims the cycle.
    assign mdu_accept = (state == ST_RUN) && !dmem_busy_i && !ex_branch_taken_i
                        && !load_use && id_mdu_start_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_BOOT;
            boot_cnt <= BOOT_INIT;
            mdu_cnt  <= '0;
        end else begin
            case (state)
                ST_BOOT: begin
                    if (boot_cnt == '0) begin
                        state <= ST_RUN;
                    end else begin
                        boot_cnt <= boot_cnt - 1'b1;
                    end
                end
                ST_RUN: begin
                    if (mdu_accept) begin
                        state   <= ST_MDU_WAIT;
                        mdu_cnt <= MDU_INIT;
                    end
                end
                ST_MDU_WAIT: begin
                    if (!dmem_busy_i) begin
                        if (mdu_cnt == '0) begin
                            state <= ST_RUN;
                        end else begin
                            mdu_cnt <= mdu_cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_BOOT;
                end
            endcase
        end
    end

    // Reset forces the boot controls combinationally so the front end is held even before the first edge.
    always_comb begin
        pc_keep_o     = 1'b0;
        ifid_keep_o   = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        freeze_o      = 1'b0;
        mdu_busy_o    = !rst_i && (state == ST_MDU_WAIT);
        state_o       = rst_i ? 2'd0 : state;

        if (rst_i || state == ST_BOOT) begin
            pc_keep_o     = 1'b1;
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
        end else if (dmem_busy_i) begin
            pc_keep_o   = 1'b1;
            ifid_keep_o = 1'b1;
            freeze_o    = 1'b1;
        end else if (state == ST_MDU_WAIT) begin
            pc_keep_o     = 1'b1;
            ifid_keep_o   = 1'b1;
            idex_bubble_o = 1'b1;
        end else if (state == ST_RUN) begin
            if (ex_branch_taken_i) begin
                ifid_flush_o  = 1'b1;
                idex_bubble_o = 1'b1;
            end else if (load_use) begin
                pc_keep_o     = 1'b1;
                ifid_keep_o   = 1'b1;
                idex_bubble_o = 1'b1;
            end else if (!id_mdu_start_i && id_jump_i) begin
                ifid_flush_o = 1'b1;
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Both counters saturate rather than wrap so a long run never reports a small value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (state != ST_BOOT) begin
            if (pc_keep_o && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (ifid_flush_o && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt;
    assign flush_cnt_o = flush_cnt;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

`ifndef SYNTHESIS
    keep_flush_exclusive : assert property (@(posedge clk_i) !(ifid_keep_o && ifid_flush_o));
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: per-cycle comparison against a counter-based behavioural model
// plus hand-computed literal expectations.
module tb_hazard_ctrl;

    localparam int REG_AW   = 5;
    localparam int BOOT_CYC = 2;
    localparam int MDU_LAT  = 4;
    localparam int CNT_W    = 32;

    // Packed control view: {pc_keep, ifid_keep, ifid_flush, idex_bubble, freeze, mdu_busy, state[1:0]}
    localparam logic [7:0] BOOTV = 8'b1011_0000;
    localparam logic [7:0] RUNV  = 8'b0000_0001;
    localparam logic [7:0] STALL = 8'b1101_0001;
    localparam logic [7:0] BRV   = 8'b0011_0001;
    localparam logic [7:0] JMPV  = 8'b0010_0001;
    localparam logic [7:0] RFRZ  = 8'b1100_1001;
    localparam logic [7:0] MDUV  = 8'b1101_0110;
    localparam logic [7:0] MFRZ  = 8'b1100_1110;

    logic              clk = 1'b0;
    logic              rst;
    logic [REG_AW-1:0] id_rs, id_rt, ex_rt;
    logic              id_uses_rs, id_uses_rt, id_jump, id_mdu_start;
    logic              ex_mem_read, ex_branch_taken, dmem_busy;
    logic              pc_keep, ifid_keep, ifid_flush, idex_bubble, freeze, mdu_busy;
    logic [1:0]        state;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    int checks   = 0;
    int failures = 0;
    logic check_en = 1'b0;

    int         m_boot_rem;
    int         m_mdu_rem;
    logic [CNT_W-1:0] m_stall;
    logic [CNT_W-1:0] m_flush;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .REG_AW(REG_AW), .BOOT_CYC(BOOT_CYC), .MDU_LAT(MDU_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_uses_rs_i(id_uses_rs), .id_uses_rt_i(id_uses_rt),
        .id_jump_i(id_jump), .id_mdu_start_i(id_mdu_start),
        .ex_mem_read_i(ex_mem_read), .ex_rt_i(ex_rt),
        .ex_branch_taken_i(ex_branch_taken), .dmem_busy_i(dmem_busy),
        .pc_keep_o(pc_keep), .ifid_keep_o(ifid_keep), .ifid_flush_o(ifid_flush),
        .idex_bubble_o(idex_bubble), .freeze_o(freeze), .mdu_busy_o(mdu_busy),
        .state_o(state), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    function automatic logic [7:0] actual_ctl();
        return {pc_keep, ifid_keep, ifid_flush, idex_bubble, freeze, mdu_busy, state};
    endfunction

    function automatic logic model_load_use();
        return ex_mem_read && (ex_rt != 0) &&
               ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
    endfunction

    // Expected controls derived from the rules: boot window, freeze, MDU window, then RUN priority.
    function automatic logic [7:0] model_ctl();
        logic in_mdu;
        in_mdu = (m_mdu_rem > 0);
        if (rst || m_boot_rem > 0) return BOOTV;
        if (dmem_busy) return {5'b11001, in_mdu, in_mdu ? 2'd2 : 2'd1};
        if (in_mdu) return MDUV;
        if (ex_branch_taken) return BRV;
        if (model_load_use()) return STALL;
        if (id_mdu_start) return RUNV;
        if (id_jump) return JMPV;
        return RUNV;
    endfunction

    always @(posedge clk) begin
        logic [7:0] e;
        e = model_ctl();
        if (rst) begin
            m_boot_rem = BOOT_CYC;
            m_mdu_rem  = 0;
            m_stall    = '0;
            m_flush    = '0;
        end else if (m_boot_rem > 0) begin
            m_boot_rem = m_boot_rem - 1;
        end else begin
            if (e[7] && m_stall != '1) m_stall = m_stall + 1'b1;
            if (e[5] && m_flush != '1) m_flush = m_flush + 1'b1;
            if (m_mdu_rem > 0) begin
                if (!dmem_busy) m_mdu_rem = m_mdu_rem - 1;
            end else if (!dmem_busy && !ex_branch_taken && !model_load_use() && id_mdu_start) begin
                m_mdu_rem = MDU_LAT;
            end
        end
    end

    always @(negedge clk) begin
        logic [CNT_W-1:0] es, ef;
        if (check_en) begin
`ifdef HAZ_PERF_CNT_EN
            es = m_stall;
            ef = m_flush;
`else
            es = '0;
            ef = '0;
`endif
            checks++;
            if (actual_ctl() !== model_ctl()) begin
                failures++;
                $display("[TB] FAIL model_ctl t=%0t: got %b expected %b", $time, actual_ctl(), model_ctl());
            end
            checks++;
            if (ifid_keep && ifid_flush) begin
                failures++;
                $display("[TB] FAIL keep_flush_excl t=%0t: got keep=%b flush=%b expected not both 1",
                         $time, ifid_keep, ifid_flush);
            end
            checks++;
            if (stall_cnt !== es || flush_cnt !== ef) begin
                failures++;
                $display("[TB] FAIL model_cnt t=%0t: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                         $time, stall_cnt, flush_cnt, es, ef);
            end
        end
    end

    task automatic applyStimulus(input logic r,
                                 input logic [REG_AW-1:0] rs, input logic urs,
                                 input logic [REG_AW-1:0] rt, input logic urt,
                                 input logic jmp, input logic mdu,
                                 input logic mr, input logic [REG_AW-1:0] ert,
                                 input logic br, input logic busy);
        rst             = r;
        id_rs           = rs;
        id_uses_rs      = urs;
        id_rt           = rt;
        id_uses_rt      = urt;
        id_jump         = jmp;
        id_mdu_start    = mdu;
        ex_mem_read     = mr;
        ex_rt           = ert;
        ex_branch_taken = br;
        dmem_busy       = busy;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] exp);
        checks++;
        if (actual_ctl() !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b", name, actual_ctl(), exp);
        end
    endtask

    task automatic checkCounters(input string name, input logic [CNT_W-1:0] es, input logic [CNT_W-1:0] ef);
        checks++;
        if (stall_cnt !== es || flush_cnt !== ef) begin
            failures++;
            $display("[TB] FAIL %s: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                     name, stall_cnt, flush_cnt, es, ef);
        end
    endtask

    task automatic runCycle(input string name, input logic [7:0] exp);
        @(negedge clk);
        checkOutput(name, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check_en = 1'b1;
        runCycle("reset_hold", BOOTV);

        idle();                                          runCycle("boot_1", BOOTV);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);  runCycle("boot_2_busy_ignored", BOOTV);
        idle();                                          runCycle("run_first", RUNV);

        applyStimulus(0, 8, 1, 0, 0, 0, 0, 1, 8, 0, 0);  runCycle("loaduse_rs", STALL);
        idle();                                          runCycle("after_loaduse", RUNV);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);  runCycle("loaduse_r0", RUNV);
        applyStimulus(0, 3, 1, 5, 1, 0, 0, 1, 5, 0, 0);  runCycle("loaduse_rt", STALL);
        applyStimulus(0, 3, 0, 5, 0, 0, 0, 1, 5, 0, 0);  runCycle("loaduse_unused", RUNV);
        applyStimulus(0, 8, 1, 0, 0, 0, 0, 0, 8, 0, 0);  runCycle("no_load", RUNV);

        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);  runCycle("jump", JMPV);
        applyStimulus(0, 8, 1, 0, 0, 1, 0, 1, 8, 0, 0);  runCycle("jump_loaduse", STALL);
        applyStimulus(0, 8, 1, 0, 0, 1, 0, 0, 0, 0, 0);  runCycle("jump_replay", JMPV);

        applyStimulus(0, 8, 1, 0, 0, 0, 1, 1, 8, 1, 0);  runCycle("branch_mdu_lu", BRV);
        idle();                                          runCycle("branch_stays_run", RUNV);
        applyStimulus(0, 8, 1, 0, 0, 1, 1, 1, 8, 1, 1);  runCycle("run_freeze", RFRZ);
        idle();                                          runCycle("after_run_freeze", RUNV);

        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);  runCycle("mdu_issue", RUNV);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);  runCycle("mdu_w1_ignores_br", MDUV);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);  runCycle("mdu_freeze_1", MFRZ);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);  runCycle("mdu_freeze_2", MFRZ);
        idle();                                          runCycle("mdu_w2", MDUV);
        idle();                                          runCycle("mdu_w3", MDUV);
        idle();                                          runCycle("mdu_w4", MDUV);
        idle();                                          runCycle("mdu_done", RUNV);

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  runCycle("reset2", BOOTV);
        idle();                                          runCycle("reset2_boot1", BOOTV);
        idle();                                          runCycle("reset2_boot2", BOOTV);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);  runCycle("cnt_jump", JMPV);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);  runCycle("cnt_mdu_issue", RUNV);
        idle();                                          runCycle("cnt_mdu_w1", MDUV);
        idle();                                          runCycle("cnt_mdu_w2", MDUV);
        idle();                                          runCycle("cnt_mdu_w3", MDUV);

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("reset_mid_mdu", BOOTV);
`ifdef HAZ_PERF_CNT_EN
        checkCounters("cnt_before_reset", 32'd3, 32'd1);
`else
        checkCounters("cnt_before_reset", 32'd0, 32'd0);
`endif
        @(posedge clk);
        #1;
        idle();
        @(negedge clk);
        checkOutput("after_reset_boot", BOOTV);
        checkCounters("cnt_after_reset", 32'd0, 32'd0);

        @(posedge clk);
        #1;
        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
